// File: rtl/pdm_blinky_multi.sv
// Multi-channel PDM LED driver: per-channel first-order sigma-delta modulator with
// optional triangle "breathe" ramp on a shared prescaled tick, plus registered readback.

module pdm_blinky_ch #(
    parameter int W    = 5,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_hit,
    input  logic [W-1:0] wr_data,
    input  logic         wr_mode,
    input  logic         tick,
    output logic [W-1:0] duty,
    output logic         mode,
    output logic         pdm
);
    localparam logic [W:0] STEP_X = (W+1)'(STEP);
    localparam logic [W:0] TOP    = {1'b0, {W{1'b1}}};

    logic [W-1:0] duty_q, duty_d, acc_q, acc_d;
    logic         mode_q, mode_d, dir_q, dir_d, pdm_q, pdm_d;
    logic [W:0]   sum, up_sum;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, duty_q};
        up_sum = {1'b0, duty_q} + STEP_X;
        acc_d  = sum[W-1:0];
        pdm_d  = sum[W];
        duty_d = duty_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        // acc is left alone on a write so a duty change never glitches the bitstream
        if (wr_hit) begin
            duty_d = wr_data;
            mode_d = wr_mode;
            dir_d  = 1'b0;
        end else if (tick && mode_q) begin
            if (!dir_q) begin
                if (up_sum >= TOP) begin
                    duty_d = TOP[W-1:0];
                    dir_d  = 1'b1;
                end else begin
                    duty_d = up_sum[W-1:0];
                end
            end else begin
                if ({1'b0, duty_q} <= STEP_X) begin
                    duty_d = '0;
                    dir_d  = 1'b0;
                end else begin
                    duty_d = duty_q - STEP_X[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            duty_q <= '0;
            acc_q  <= '0;
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
            pdm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            acc_q  <= acc_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            pdm_q  <= pdm_d;
        end
    end

    assign duty = duty_q;
    assign mode = mode_q;
    assign pdm  = pdm_q;
endmodule

module pdm_blinky_multi #(
    parameter  int N_CH     = 4,
    parameter  int W        = 5,
    parameter  int PRESCALE = 4,
    parameter  int STEP     = 1,
    localparam int AW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_data,
    input  logic            wr_mode,
    input  logic [AW-1:0]   rd_addr,
    output logic [W-1:0]    rd_duty,
    output logic            rd_mode,
    output logic            tick,
    output logic [N_CH-1:0] pdm_out
);
    logic [PRESCALE-1:0]        cnt_q, cnt_d;
    logic                       tick_q, tick_d;
    logic [W-1:0]               rd_duty_q, rd_duty_d;
    logic                       rd_mode_q, rd_mode_d;
    logic [N_CH-1:0]            wr_hit, mode_w;
    logic [N_CH-1:0][W-1:0]     duty_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // out-of-range addresses simply match no channel
        assign wr_hit[i] = wr_en && (wr_addr == AW'(i));
        pdm_blinky_ch #(.W(W), .STEP(STEP)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_hit  (wr_hit[i]),
            .wr_data (wr_data),
            .wr_mode (wr_mode),
            .tick    (tick_q),
            .duty    (duty_w[i]),
            .mode    (mode_w[i]),
            .pdm     (pdm_out[i])
        );
    end

    always_comb begin
        cnt_d     = cnt_q + PRESCALE'(1);
        tick_d    = &cnt_q;
        rd_duty_d = '0;
        rd_mode_d = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_duty_d = duty_w[i];
                rd_mode_d = mode_w[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            rd_duty_q <= '0;
            rd_mode_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            rd_duty_q <= rd_duty_d;
            rd_mode_q <= rd_mode_d;
        end
    end

    assign tick    = tick_q;
    assign rd_duty = rd_duty_q;
    assign rd_mode = rd_mode_q;
endmodule

// File: tb/tb_pdm_blinky_multi.sv
// Scoreboard bench for pdm_blinky_multi: stimulus queues expectations tagged with the
// cycle they are due, a negedge monitor compares them against the DUT outputs.

module tb_pdm_blinky_multi;
    localparam int K_RD = 0, K_PDM = 1, K_PDMV = 2, K_TICK = 3, K_WIN = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en, wr_mode;
    logic [1:0] wr_addr, rd_addr;
    logic [4:0] wr_data, rd_duty;
    logic       rd_mode, tick;
    logic [3:0] pdm_out;

    logic       b_wr_en, b_wr_mode;
    logic [1:0] b_wr_addr, b_rd_addr;
    logic [4:0] b_wr_data, b_rd_duty;
    logic       b_rd_mode, b_tick;
    logic [2:0] b_pdm_out;

    pdm_blinky_multi #(.N_CH(4), .W(5), .PRESCALE(4), .STEP(1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mode(wr_mode), .rd_addr(rd_addr), .rd_duty(rd_duty), .rd_mode(rd_mode),
        .tick(tick), .pdm_out(pdm_out));

    // three-channel copy so an address past the last channel is representable
    pdm_blinky_multi #(.N_CH(3), .W(5), .PRESCALE(4), .STEP(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_mode(b_wr_mode), .rd_addr(b_rd_addr), .rd_duty(b_rd_duty), .rd_mode(b_rd_mode),
        .tick(b_tick), .pdm_out(b_pdm_out));

    always #5 clk = ~clk;

    typedef struct {
        int    due;
        int    kind;
        int    dut;
        int    ch;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   r_edge = 0;
    int   cum[4][8192];

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    task automatic do_check(input chk_t e);
        int act;
        act = 0;
        case (e.kind)
            K_RD:   act = e.dut != 0 ? ((int'(b_rd_mode) << 8) | int'(b_rd_duty))
                                     : ((int'(rd_mode) << 8) | int'(rd_duty));
            K_PDM:  act = int'(pdm_out[e.ch]);
            K_PDMV: act = e.dut != 0 ? int'(b_pdm_out) : int'(pdm_out);
            K_TICK: act = e.dut != 0 ? int'(b_tick) : int'(tick);
            K_WIN:  act = cum[e.ch][e.due] - cum[e.ch][e.due-32];
            default: act = -1;
        endcase
        checks++;
        if (act != e.exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, e.due, act, e.exp);
        end
    endtask

    // monitor: accumulate pdm ones history, then retire every expectation that is due
    initial forever begin
        @(negedge clk);
        if (edge_n > 0 && edge_n < 8192)
            for (int c = 0; c < 4; c++) cum[c][edge_n] = cum[c][edge_n-1] + int'(pdm_out[c]);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= edge_n) begin
                do_check(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int due, input int kind, input int d, input int ch,
                        input int exp, input string name);
        chk_t e;
        e.due = due; e.kind = kind; e.dut = d; e.ch = ch; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int now();
        return edge_n + 1;
    endfunction

    task automatic wr(input int ch, input int d, input int m);
        wr_en = 1'b1; wr_addr = 2'(ch); wr_data = 5'(d); wr_mode = (m != 0);
        step();
        wr_en = 1'b0;
    endtask

    task automatic b_wr(input int ch, input int d, input int m);
        b_wr_en = 1'b1; b_wr_addr = 2'(ch); b_wr_data = 5'(d); b_wr_mode = (m != 0);
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while (((now() - r_edge) % 16) != ph && n < 32) begin
            step();
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2, w, x;
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 1'b0; rd_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_mode = 1'b0; b_rd_addr = '0;

        // reset state
        push(3, K_RD, 0, 0, 0, "rst_rd");
        push(3, K_PDMV, 0, 0, 0, "rst_pdm");
        push(3, K_TICK, 0, 0, 0, "rst_tick");
        push(4, K_RD, 1, 0, 0, "rst_b_rd");
        push(4, K_PDMV, 1, 0, 0, "rst_b_pdm");
        push(4, K_TICK, 1, 0, 0, "rst_b_tick");
        repeat (5) step();
        r_edge = now();
        reset_n = 1'b1;

        // idle: no ones, tick every 16 cycles
        for (int c = 0; c < 4; c++) push(r_edge + 63, K_WIN, 0, c, 0, "idle_win");
        push(r_edge + 14, K_TICK, 0, 0, 0, "tick_pre");
        push(r_edge + 15, K_TICK, 0, 0, 1, "tick_first");
        push(r_edge + 16, K_TICK, 0, 0, 0, "tick_post");
        push(r_edge + 31, K_TICK, 0, 0, 1, "tick_second");
        push(r_edge + 47, K_TICK, 0, 0, 1, "tick_third");
        push(r_edge + 40, K_RD, 0, 0, 0, "idle_rd");
        drain();

        // static duties; ch0 from acc=0 fires on every 4th cycle
        e = now();
        wr(0, 8, 0);
        push(e + 1, K_RD, 0, 0, 8, "ch0_rd");
        push(e + 1, K_PDM, 0, 0, 0, "ch0_bit1");
        push(e + 3, K_PDM, 0, 0, 0, "ch0_bit3");
        push(e + 4, K_PDM, 0, 0, 1, "ch0_bit4");
        push(e + 5, K_PDM, 0, 0, 0, "ch0_bit5");
        push(e + 8, K_PDM, 0, 0, 1, "ch0_bit8");
        wr(1, 'h1a, 0);
        wr(2, 'h00, 0);
        wr(3, 'h1f, 0);
        rd_addr = 2'd3;
        push(e + 4, K_RD, 0, 0, 'h1f, "ch3_rd");
        push(e + 43, K_WIN, 0, 0, 8, "win_ch0");
        push(e + 43, K_WIN, 0, 1, 26, "win_ch1");
        push(e + 43, K_WIN, 0, 2, 0, "win_ch2");
        push(e + 43, K_WIN, 0, 3, 31, "win_ch3");
        drain();

        // ch1 breathe from 0x1e: saturate at top, ramp down to 0, back up
        rd_addr = 2'd1;
        wait_phase(3);
        e = now();
        wr(1, 'h1e, 1);
        push(e + 1, K_RD, 0, 0, 'h11e, "br_wr");
        push(e + 12, K_TICK, 0, 0, 1, "br_tick");
        push(e + 13, K_RD, 0, 0, 'h11e, "br_hold");
        push(e + 14, K_RD, 0, 0, 'h11f, "br_top");
        push(e + 30, K_RD, 0, 0, 'h11e, "br_down1");
        push(e + 46, K_RD, 0, 0, 'h11d, "br_down2");
        push(e + 494, K_RD, 0, 0, 'h101, "br_one");
        push(e + 510, K_RD, 0, 0, 'h100, "br_zero");
        push(e + 526, K_RD, 0, 0, 'h101, "br_up");
        drain();

        // write on a tick cycle: ch2 takes the write, ch1 still steps
        wait_phase(2);
        wr(1, 'h0a, 1);
        rd_addr = 2'd2;
        e2 = now();
        wr(2, 'h05, 1);
        push(e2 + 1, K_RD, 0, 0, 'h105, "ch2_br_wr");
        push(e2 + 14, K_RD, 0, 0, 'h106, "ch2_br_step");
        push(e2 + 28, K_TICK, 0, 0, 1, "coll_tick");
        repeat (28) step();
        w = now();
        wr(2, 'h0f, 1);
        push(w + 1, K_RD, 0, 0, 'h10f, "coll_ch2");
        step();
        rd_addr = 2'd1;
        push(w + 2, K_RD, 0, 0, 'h10c, "coll_ch1");
        step();
        rd_addr = 2'd2;
        push(w + 16, K_RD, 0, 0, 'h10f, "coll_hold");
        push(w + 17, K_RD, 0, 0, 'h110, "coll_next");
        drain();

        // out-of-range write/read on the three-channel copy
        e = now();
        b_wr(0, 'h09, 0);
        b_wr(3, 'h11, 1);
        push(e + 1, K_RD, 1, 0, 'h009, "b_ch0_rd");
        push(e + 2, K_RD, 1, 0, 'h009, "oor_wr_ch0");
        step();
        b_rd_addr = 2'd3;
        push(e + 3, K_RD, 1, 0, 0, "oor_rd");
        step();
        b_rd_addr = 2'd2;
        push(e + 4, K_RD, 1, 0, 0, "oor_wr_ch2");
        step();
        b_rd_addr = 2'd0;
        drain();

        // reset mid-ramp, with a write held during reset
        x = now();
        reset_n = 1'b0;
        push(x, K_RD, 0, 0, 0, "mid_rst_rd");
        push(x, K_PDMV, 0, 0, 0, "mid_rst_pdm");
        push(x, K_TICK, 0, 0, 0, "mid_rst_tick");
        push(x, K_RD, 1, 0, 0, "mid_rst_b_rd");
        step();
        wr(0, 'h1f, 0);
        reset_n = 1'b1;
        r_edge = now();
        rd_addr = 2'd0;
        push(x + 2, K_RD, 0, 0, 0, "rst_wr_ch0");
        step();
        rd_addr = 2'd1;
        push(x + 3, K_RD, 0, 0, 0, "rst_ch1");
        push(x + 3, K_PDMV, 0, 0, 0, "rst_pdm_after");
        push(r_edge + 14, K_TICK, 0, 0, 0, "rst_tick_pre");
        push(r_edge + 15, K_TICK, 0, 0, 1, "rst_tick_first");
        for (int c = 0; c < 4; c++) push(r_edge + 40, K_WIN, 0, c, 0, "rst_win");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
